max7219_receiver: RTL and testbench
===================================

# max7219_receiver

SPI receive-side model of the MAX7219-style display driver that the stopwatch's SPI master writes to. It synchronises CS/SCK/MOSI into the system clock domain and assembles 16-bit MSB-first frames. It applies each complete frame to a shadow register file and exposes decoded seven-segment patterns. It serves as an on-chip loopback checker for the display path and as the receive end for a second board.

## Interface
Parameters:
- SYNC_STAGES, 2: flip-flop depth of the CS/SCK/MOSI synchronisers (minimum 2).

Ports:
- clk  in  1  system clock (1 MHz)
- res  in  1  reset, asynchronous, active-low
- cs_in  in  1  SPI chip select, active-low, asynchronous to clk
- sck_in  in  1  SPI clock, data sampled on rising edge
- mosi_in  in  1  SPI data, MSB first
- digit_sel  in  3  selects digit register 0..7 (addresses 0x1..0x8)
- word_valid  out  1  one-cycle pulse: exactly 16 bits framed by CS
- word_out  out  16  last accepted frame; held until next accept
- frame_error  out  1  one-cycle pulse: CS rose after 1..15 or ≥17 bits
- shutdown_n  out  1  register 0xC bit 0
- decode_mode  out  8  register 0x9
- intensity  out  4  register 0xA[3:0]
- scan_limit  out  3  register 0xB[2:0]
- display_test  out  1  register 0xF bit 0
- digit_seg  out  8  {DP,A,B,C,D,E,F,G} for digit_sel, combinational from registers

## Operation
- All three SPI inputs pass through identical SYNC_STAGES synchronisers; SCK rise and CS rise/fall are detected on the last stage plus one history flop; MOSI is taken from the same stage as SCK.
- FSM states: IDLE, SHIFT.
  - IDLE: on synchronised CS falling, clear bit counter and shift register, go to SHIFT.
  - SHIFT: each SCK rise shifts MOSI into bit 0 and increments the 5-bit bit counter (saturates at 17). On CS rising: count==16 gives accept; count 0 is silently ignored; any other count pulses frame_error. All paths return to IDLE.
- SCK edges while in IDLE are ignored.
- Accept: word_out←shift register and word_valid pulses. Address = word[11:8]; word[15:12] ignored.
  - 0x0: no-op.
  - 0x1–0x8: digit[addr-1]←data.
  - 0x9: decode_mode.
  - 0xA: intensity.
  - 0xB: scan_limit.
  - 0xC: shutdown_n.
  - 0xF: display_test.
  - 0xD, 0xE: no-op.
- digit_seg, digit_sel = n:
  - decode_mode[n]=0: raw digit[n].
  - decode_mode[n]=1: Code B on data[3:0], DP = data[7], data[6:4] ignored.
  - Code B: 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A('-')=01 B('E')=4F C('H')=37 D('L')=0E E('P')=67 F(blank)=00.

## Timing
- Reset values: all registers, word_out, shift register and counter 0; word_valid, frame_error 0; shutdown_n 0; state IDLE.
- Reset asserted mid-frame discards the partial frame; no pulse is issued after release.
- SCK high and low phases each ≥2 clk cycles; CS high ≥2 cycles between frames.
- Latency: register and word_valid update SYNC_STAGES+2 clk cycles after raw CS rises.
- The register write and the word_valid pulse occur in the same cycle.
- CS falling and a SCK rise detected in the same cycle: the frame starts and that edge is not counted.
- CS rising and a SCK rise detected in the same cycle: the bit is shifted before the count is evaluated.

## Structure
- Package max7219_pkg:
  - address localparams: ADDR_NOOP, ADDR_DIGIT0..7, ADDR_DECODE, ADDR_INTENSITY, ADDR_SCANLIMIT, ADDR_SHUTDOWN, ADDR_TEST.
  - function code_b_seg(4-bit) returning 7 bits.
  - FRAME_BITS=16.
- Sub-module spi_frame_receiver: synchronisers, edge detect, FSM, shift/count, accept and error pulses.
- The top holds the register file and the segment mux.

## Test plan
- Reset, then frame 0x0C01 with 2-cycle SCK phases -> one word_valid; word_out=0x0C01; shutdown_n=1.
- Frames 0x09FF then 0x0385, digit_sel=2 -> decode_mode=0xFF; digit_seg=0xDB.
- 0x09FE then 0x0185, digit_sel=0 -> digit_seg=0x85 (raw); 0x010F with decode bit set -> digit_seg=0x00.
- 15-bit frame, then 17-bit frame -> frame_error pulses twice; no word_valid; registers and word_out unchanged.
- CS low→high with no SCK -> no word_valid, no frame_error.
- Assert res after bit 8 of 0x0A07, release, then send 0x0A03 -> intensity=3; exactly one word_valid.

Source files
------------

// File: rtl/max7219_pkg.sv
// max7219_pkg
//   Shared definitions for the MAX7219-style SPI receiver:
//   - frame length and register address map
//   - receiver FSM state type
//   - Code B font lookup (digit code -> {A,B,C,D,E,F,G})
package max7219_pkg;

   localparam int FRAME_BITS = 16;

   localparam logic [3:0] ADDR_NOOP      = 4'h0;
   localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
   localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
   localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
   localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
   localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
   localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
   localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
   localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
   localparam logic [3:0] ADDR_DECODE    = 4'h9;
   localparam logic [3:0] ADDR_INTENSITY = 4'hA;
   localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
   localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
   localparam logic [3:0] ADDR_TEST      = 4'hF;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } rx_state_t;

   // Code B font: 0-9, '-', 'E', 'H', 'L', 'P', blank.
   function automatic logic [6:0] code_b_seg(input logic [3:0] code);
      logic [6:0] seg;
      case (code)
         4'h0:    seg = 7'h7E;
         4'h1:    seg = 7'h30;
         4'h2:    seg = 7'h6D;
         4'h3:    seg = 7'h79;
         4'h4:    seg = 7'h33;
         4'h5:    seg = 7'h5B;
         4'h6:    seg = 7'h5F;
         4'h7:    seg = 7'h70;
         4'h8:    seg = 7'h7F;
         4'h9:    seg = 7'h7B;
         4'hA:    seg = 7'h01;
         4'hB:    seg = 7'h4F;
         4'hC:    seg = 7'h37;
         4'hD:    seg = 7'h0E;
         4'hE:    seg = 7'h67;
         default: seg = 7'h00;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/max7219_spi_frame_receiver.sv
// spi_frame_receiver
//   Synchronises CS/SCK/MOSI into the clk domain, detects edges and
//   assembles MSB-first frames. A frame ending with exactly FRAME_BITS
//   SCK rises produces a one-cycle o_accept with the frame on o_word;
//   any other non-zero count produces a one-cycle o_frame_error.
// Ports:
//   i_clk, i_res_n        clock, async active-low reset
//   i_cs, i_sck, i_mosi   raw SPI inputs (asynchronous)
//   o_accept              one-cycle pulse, frame complete
//   o_word[15:0]          assembled frame, valid while o_accept is high
//   o_frame_error         one-cycle pulse, wrong bit count
//   o_state               current receiver state
module spi_frame_receiver
   import max7219_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        i_clk,
   input  logic        i_res_n,
   input  logic        i_cs,
   input  logic        i_sck,
   input  logic        i_mosi,
   output logic        o_accept,
   output logic [15:0] o_word,
   output logic        o_frame_error,
   output rx_state_t   o_state
);

   localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
   localparam logic [4:0] CNT_SAT  = 5'(FRAME_BITS + 1);

   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_sck_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic                   r_cs_hist;
   logic                   r_sck_hist;

   rx_state_t   r_state;
   logic [4:0]  r_bit_cnt;
   logic [15:0] r_shift;
   logic        r_accept;
   logic        r_error;

   logic        w_cs_s, w_sck_s, w_mosi_s;
   logic        w_cs_fall, w_cs_rise, w_sck_rise;
   logic [4:0]  w_cnt_next;
   logic [15:0] w_shift_next;

   // CS idles high, so its synchroniser resets high to avoid a false
   // edge right after reset release.
   always_ff @(posedge i_clk or negedge i_res_n) begin
      if (!i_res_n) begin
         r_cs_sync   <= '1;
         r_sck_sync  <= '0;
         r_mosi_sync <= '0;
         r_cs_hist   <= 1'b1;
         r_sck_hist  <= 1'b0;
      end else begin
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs};
         r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
         r_cs_hist   <= w_cs_s;
         r_sck_hist  <= w_sck_s;
      end
   end

   assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
   assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
   assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
   assign w_cs_fall  = r_cs_hist & ~w_cs_s;
   assign w_cs_rise  = ~r_cs_hist & w_cs_s;
   assign w_sck_rise = ~r_sck_hist & w_sck_s;

   // Next shift/count including an SCK rise in this cycle, so a bit that
   // coincides with CS rising is counted before the frame is judged.
   assign w_cnt_next   = (w_sck_rise && (r_bit_cnt < CNT_SAT)) ? r_bit_cnt + 5'd1 : r_bit_cnt;
   assign w_shift_next = w_sck_rise ? {r_shift[14:0], w_mosi_s} : r_shift;

   always_ff @(posedge i_clk or negedge i_res_n) begin
      if (!i_res_n) begin
         r_state   <= ST_IDLE;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_accept  <= 1'b0;
         r_error   <= 1'b0;
      end else begin
         r_accept <= 1'b0;
         r_error  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // An SCK rise in the same cycle as CS falling is dropped.
               if (w_cs_fall) begin
                  r_bit_cnt <= '0;
                  r_shift   <= '0;
                  r_state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               r_bit_cnt <= w_cnt_next;
               r_shift   <= w_shift_next;
               if (w_cs_rise) begin
                  r_state <= ST_IDLE;
                  if (w_cnt_next == CNT_FULL) begin
                     r_accept <= 1'b1;
                  end else if (w_cnt_next != 5'd0) begin
                     r_error <= 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // r_shift is frozen in IDLE, so it still holds the frame during o_accept.
   assign o_accept      = r_accept;
   assign o_word        = r_shift;
   assign o_frame_error = r_error;
   assign o_state       = r_state;

endmodule

// File: rtl/max7219_receiver.sv
// max7219_receiver
//   Receive side of a MAX7219-style display driver. Accepted SPI frames
//   are written into a shadow register file; digit_seg shows the segment
//   pattern of the digit chosen by digit_sel (raw or Code B decoded).
// Ports:
//   clk, res                   clock, async active-low reset
//   cs_in, sck_in, mosi_in     SPI inputs (asynchronous)
//   digit_sel[2:0]             digit register to display
//   word_valid                 one-cycle pulse per accepted frame
//   word_out[15:0]             last accepted frame
//   frame_error                one-cycle pulse per malformed frame
//   shutdown_n, decode_mode, intensity, scan_limit, display_test
//                              control register contents
//   digit_seg[7:0]             {DP,A,B,C,D,E,F,G} of selected digit
module max7219_receiver
   import max7219_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        res,
   input  logic        cs_in,
   input  logic        sck_in,
   input  logic        mosi_in,
   input  logic [2:0]  digit_sel,
   output logic        word_valid,
   output logic [15:0] word_out,
   output logic        frame_error,
   output logic        shutdown_n,
   output logic [7:0]  decode_mode,
   output logic [3:0]  intensity,
   output logic [2:0]  scan_limit,
   output logic        display_test,
   output logic [7:0]  digit_seg,
   output rx_state_t   rx_state
);

   logic        w_rx_accept;
   logic [15:0] w_rx_word;
   logic [3:0]  w_addr;
   logic [7:0]  w_data;
   logic [7:0]  w_raw;

   logic [7:0]  r_digit [8];
   logic [7:0]  r_decode;
   logic [3:0]  r_intensity;
   logic [2:0]  r_scan_limit;
   logic        r_shutdown_n;
   logic        r_test;
   logic        r_word_valid;
   logic [15:0] r_word_out;

   spi_frame_receiver #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_rx (
      .i_clk         (clk),
      .i_res_n       (res),
      .i_cs          (cs_in),
      .i_sck         (sck_in),
      .i_mosi        (mosi_in),
      .o_accept      (w_rx_accept),
      .o_word        (w_rx_word),
      .o_frame_error (frame_error),
      .o_state       (rx_state)
   );

   assign w_addr = w_rx_word[11:8];
   assign w_data = w_rx_word[7:0];

   // Register write and word_valid land in the same cycle.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         for (int i = 0; i < 8; i++) r_digit[i] <= '0;
         r_decode     <= '0;
         r_intensity  <= '0;
         r_scan_limit <= '0;
         r_shutdown_n <= 1'b0;
         r_test       <= 1'b0;
         r_word_valid <= 1'b0;
         r_word_out   <= '0;
      end else begin
         r_word_valid <= w_rx_accept;
         if (w_rx_accept) begin
            r_word_out <= w_rx_word;
            case (w_addr)
               ADDR_DIGIT0:    r_digit[0]   <= w_data;
               ADDR_DIGIT1:    r_digit[1]   <= w_data;
               ADDR_DIGIT2:    r_digit[2]   <= w_data;
               ADDR_DIGIT3:    r_digit[3]   <= w_data;
               ADDR_DIGIT4:    r_digit[4]   <= w_data;
               ADDR_DIGIT5:    r_digit[5]   <= w_data;
               ADDR_DIGIT6:    r_digit[6]   <= w_data;
               ADDR_DIGIT7:    r_digit[7]   <= w_data;
               ADDR_DECODE:    r_decode     <= w_data;
               ADDR_INTENSITY: r_intensity  <= w_data[3:0];
               ADDR_SCANLIMIT: r_scan_limit <= w_data[2:0];
               ADDR_SHUTDOWN:  r_shutdown_n <= w_data[0];
               ADDR_TEST:      r_test       <= w_data[0];
               default: ;      // ADDR_NOOP, 0xD, 0xE
            endcase
         end
      end
   end

   // Decoded digits keep DP from bit 7; bits 6:4 are ignored.
   always_comb begin
      w_raw     = r_digit[digit_sel];
      digit_seg = w_raw;
      if (r_decode[digit_sel]) digit_seg = {w_raw[7], code_b_seg(w_raw[3:0])};
   end

   assign word_valid   = r_word_valid;
   assign word_out     = r_word_out;
   assign shutdown_n   = r_shutdown_n;
   assign decode_mode  = r_decode;
   assign intensity    = r_intensity;
   assign scan_limit   = r_scan_limit;
   assign display_test = r_test;

endmodule

// File: tb/tb_max7219_receiver.sv
// Testbench for max7219_receiver: directed steps from the plan followed
// by random frames, all checked against a register-map model.
module tb_max7219_receiver;
   import max7219_pkg::*;

   localparam int SYNC   = 2;
   localparam int LAT    = SYNC + 2;

   logic        clk = 1'b0;
   logic        res;
   logic        cs_in, sck_in, mosi_in;
   logic [2:0]  digit_sel;
   logic        word_valid, frame_error, shutdown_n, display_test;
   logic [15:0] word_out;
   logic [7:0]  decode_mode, digit_seg;
   logic [3:0]  intensity;
   logic [2:0]  scan_limit;
   rx_state_t   rx_state;

   max7219_receiver #(.SYNC_STAGES(SYNC)) dut (
      .clk          (clk),
      .res          (res),
      .cs_in        (cs_in),
      .sck_in       (sck_in),
      .mosi_in      (mosi_in),
      .digit_sel    (digit_sel),
      .word_valid   (word_valid),
      .word_out     (word_out),
      .frame_error  (frame_error),
      .shutdown_n   (shutdown_n),
      .decode_mode  (decode_mode),
      .intensity    (intensity),
      .scan_limit   (scan_limit),
      .display_test (display_test),
      .digit_seg    (digit_seg),
      .rx_state     (rx_state)
   );

   // ---------------- clock / cycle counter ----------------
   always #500 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   // ---------------- counters / scoreboard ----------------
   int n_tests = 0;
   int n_fail  = 0;
   int n_valid = 0;
   int n_err   = 0;
   int exp_valid = 0;
   int exp_err   = 0;
   int rise_cyc  = 0;
   logic [15:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [6:0] code_b_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                   7'h7F, 7'h7B, 7'h01, 7'h4F, 7'h37, 7'h0E, 7'h67, 7'h00};
   logic [7:0]  m_digit [8];
   logic [7:0]  m_decode;
   logic [3:0]  m_intensity;
   logic [2:0]  m_scan;
   logic        m_shutdown_n, m_test;
   logic [15:0] m_word;

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_digit[i] = 8'h00;
      m_decode = 8'h00; m_intensity = 4'h0; m_scan = 3'h0;
      m_shutdown_n = 1'b0; m_test = 1'b0; m_word = 16'h0000;
   endtask

   task automatic model_apply(input logic [15:0] w);
      int a;
      a = int'(w[11:8]);
      m_word = w;
      if (a >= 1 && a <= 8) m_digit[a-1] = w[7:0];
      else if (a == 9)  m_decode     = w[7:0];
      else if (a == 10) m_intensity  = w[3:0];
      else if (a == 11) m_scan       = w[2:0];
      else if (a == 12) m_shutdown_n = w[0];
      else if (a == 15) m_test       = w[0];
   endtask

   function automatic logic [7:0] model_seg(input int n);
      logic [7:0] d;
      d = m_digit[n];
      if (m_decode[n]) return {d[7], code_b_tab[d[3:0]]};
      return d;
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (word_valid) begin
         n_valid++;
         check("latency", cyc - rise_cyc, LAT);
         if (exp_q.size() == 0) check("unexpected_word", {16'h0, word_out}, 32'hFFFF_FFFF);
         else check("word_out_at_valid", {16'h0, word_out}, {16'h0, exp_q.pop_front()});
      end
      if (frame_error) n_err++;
   end

   // ---------------- driver tasks ----------------
   task automatic wait_cyc(input int k);
      repeat (k) @(negedge clk);
   endtask

   // Sends n bits of data MSB-first; optionally raises CS to end the frame.
   task automatic send_bits(input int n, input logic [31:0] data, input bit raise_cs);
      cs_in = 1'b0;
      wait_cyc($urandom_range(2, 3));
      for (int i = 0; i < n; i++) begin
         mosi_in = data[n-1-i];
         sck_in  = 1'b0;
         wait_cyc($urandom_range(2, 3));
         sck_in  = 1'b1;
         wait_cyc($urandom_range(2, 3));
      end
      sck_in = 1'b0;
      wait_cyc(2);
      if (raise_cs) begin
         if (n == FRAME_BITS) begin
            exp_q.push_back(data[15:0]);
            exp_valid++;
         end else if (n != 0) begin
            exp_err++;
         end
         cs_in    = 1'b1;
         rise_cyc = cyc;
         wait_cyc(LAT + 4);
         if (n == FRAME_BITS) model_apply(data[15:0]);
      end
   endtask

   task automatic send_frame(input logic [15:0] w);
      send_bits(FRAME_BITS, {16'h0, w}, 1'b1);
   endtask

   task automatic check_all(input string tag);
      check({tag, ":word_out"},     {16'h0, word_out}, {16'h0, m_word});
      check({tag, ":shutdown_n"},   {31'h0, shutdown_n}, {31'h0, m_shutdown_n});
      check({tag, ":decode_mode"},  {24'h0, decode_mode}, {24'h0, m_decode});
      check({tag, ":intensity"},    {28'h0, intensity}, {28'h0, m_intensity});
      check({tag, ":scan_limit"},   {29'h0, scan_limit}, {29'h0, m_scan});
      check({tag, ":display_test"}, {31'h0, display_test}, {31'h0, m_test});
      check({tag, ":valid_count"},  n_valid, exp_valid);
      check({tag, ":error_count"},  n_err, exp_err);
      for (int s = 0; s < 8; s++) begin
         digit_sel = 3'(s);
         #1;
         check({tag, ":digit_seg"}, {24'h0, digit_seg}, {24'h0, model_seg(s)});
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      res = 1'b0; cs_in = 1'b1; sck_in = 1'b0; mosi_in = 1'b0; digit_sel = 3'd0;
      model_reset();
      wait_cyc(3);
      res = 1'b1;
      wait_cyc(4);
      check_all("reset");
      check("reset:word_valid",  {31'h0, word_valid}, 0);
      check("reset:frame_error", {31'h0, frame_error}, 0);

      // Shutdown register
      send_frame(16'h0C01);
      check("0C01:word_out", {16'h0, word_out}, 32'h0C01);
      check("0C01:shutdown_n", {31'h0, shutdown_n}, 1);
      check_all("0C01");

      // Decode all digits, Code B '5' with DP on digit 2
      send_frame(16'h09FF);
      send_frame(16'h0385);
      digit_sel = 3'd2; #1;
      check("0385:decode_mode", {24'h0, decode_mode}, 32'hFF);
      check("0385:digit_seg", {24'h0, digit_seg}, 32'hDB);
      check_all("0385");

      // Raw digit 0, then blank code with decode on
      send_frame(16'h09FE);
      send_frame(16'h0185);
      digit_sel = 3'd0; #1;
      check("0185:digit_seg_raw", {24'h0, digit_seg}, 32'h85);
      send_frame(16'h09FF);
      send_frame(16'h010F);
      digit_sel = 3'd0; #1;
      check("010F:digit_seg_blank", {24'h0, digit_seg}, 32'h00);
      check_all("010F");

      // Bad lengths
      send_bits(15, 32'h0000_0A05, 1'b1);
      send_bits(17, 32'h0001_0A05, 1'b1);
      check("badlen:word_out", {16'h0, word_out}, 32'h010F);
      check_all("badlen");

      // Empty CS pulse
      send_bits(0, 32'h0, 1'b1);
      check_all("empty_cs");

      // Reset in the middle of a frame
      send_bits(8, 32'h0000_0A07, 1'b0);
      res = 1'b0; cs_in = 1'b1; sck_in = 1'b0;
      model_reset();
      wait_cyc(3);
      res = 1'b1;
      wait_cyc(4);
      send_frame(16'h0A03);
      check("reset_mid:intensity", {28'h0, intensity}, 3);
      check_all("reset_mid");

      // Random frames, mixed with occasional bad lengths
      for (int it = 0; it < 40; it++) begin
         int n;
         logic [31:0] d;
         d = $urandom;
         case ($urandom_range(0, 7))
            0:       n = 0;
            1:       n = $urandom_range(1, 15);
            2:       n = $urandom_range(17, 20);
            default: n = FRAME_BITS;
         endcase
         send_bits(n, d, 1'b1);
         check_all("random");
      end

      check("final:queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #80ms;
      n_tests++;
      n_fail++;
      $display("FAIL timeout: observed no completion expected finish");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "timeout");
   end

endmodule
